cnt_checker: RTL and testbench
==============================

CNT_CHECKER -- requirements
Module: cnt_checker

Interface
REQ-001 Parameter WIDTH, default 10, is the width of the monitored count.
REQ-002 Parameter LOCK_N, default 4, is the number of consecutive in-sequence samples needed to lock (legal range 1..15).
REQ-003 sclk  input  1  sole clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 cnt_in  input  WIDTH  count value under check.
REQ-006 cnt_vld  input  1  cnt_in is sampled only on edges where cnt_vld=1.
REQ-007 clr  input  1  synchronous clear of the error statistics.
REQ-008 locked  output  1  checker is in the LOCK state.
REQ-009 err_pulse  output  1  one-cycle pulse per sequence break detected while locked.
REQ-010 err_cnt  output  16  saturating count of sequence breaks.
REQ-011 exp_cnt  output  WIDTH  next expected count value.

Function
REQ-012 The states SHALL be IDLE, ACQ and LOCK, with a run counter of 4 bits.
REQ-013 With cnt_vld=0, state, run counter, exp_cnt, err_cnt and locked SHALL hold, and err_pulse SHALL be 0.
REQ-014 IDLE plus a valid sample: exp_cnt<=cnt_in+1 mod 2^WIDTH, run<=1; next state LOCK if LOCK_N=1, else ACQ.
REQ-015 ACQ plus a valid sample equal to exp_cnt: exp_cnt<=cnt_in+1, run<=run+1; next state LOCK when run+1=LOCK_N.
REQ-016 ACQ plus a valid sample not equal to exp_cnt: exp_cnt<=cnt_in+1, run<=1, stay in ACQ, and err_pulse SHALL NOT assert.
REQ-017 LOCK plus a valid match: exp_cnt<=cnt_in+1, stay in LOCK.
REQ-018 LOCK plus a valid mismatch: err_pulse=1 for exactly the next cycle, err_cnt increments, exp_cnt<=cnt_in+1, run<=1, next state ACQ.
REQ-019 Wrap-around from 2^WIDTH-1 to 0 SHALL count as a match; exp_cnt SHALL be computed modulo 2^WIDTH.
REQ-020 err_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-021 All outputs SHALL be registered, so the response to a sample is visible one sclk after the sampling edge.
REQ-022 locked SHALL equal (state==LOCK) after each edge.
REQ-023 If clr=1 and a LOCK mismatch occur on the same edge, err_cnt SHALL become 0 and err_pulse SHALL still assert.
REQ-024 clr SHALL NOT affect the state, run counter or exp_cnt.

Reset
REQ-025 When rst_n=0 at an edge: state=IDLE, run=0, exp_cnt=0, err_cnt=0, err_pulse=0, locked=0; reset overrides clr and cnt_vld.
REQ-026 Reset asserted in mid-operation, including in LOCK, SHALL discard lock status without producing err_pulse.
REQ-027 After reset is released, the first valid sample SHALL be handled per REQ-014.

Configuration
REQ-028 Macro CNT_CHK_STAT_EN, when defined, SHALL compile in the err_cnt register and the clr logic per REQ-018, REQ-020 and REQ-023.
REQ-029 When CNT_CHK_STAT_EN is undefined, err_cnt SHALL be constant 0 and clr SHALL be ignored; err_pulse, locked and exp_cnt behave identically.

Verification
REQ-030 Reset, then an incrementing stream 0,1,2,3 on cnt_vld=1 -> locked=1 one cycle after the 4th sample, exp_cnt=4, err_pulse never high.
REQ-031 Locked at exp_cnt=10, then feed 12 -> err_pulse high for one cycle, err_cnt=1, locked=0, exp_cnt=13; then 13,14,15 -> relocked.
REQ-032 Locked, then stream 1022,1023,0,1 with WIDTH=10 -> no err_pulse, exp_cnt=2 at the end.
REQ-033 Locked, with cnt_vld toggling 1,0,0,1 on values 5,x,x,6 -> samples taken only when cnt_vld=1, locked stays 1, no error.
REQ-034 err_cnt preloaded to 16'hFFFF by repeated breaks, then one more break -> err_cnt stays FFFF; then clr together with a break -> err_cnt=0 and err_pulse=1.
REQ-035 While in LOCK, hold rst_n=0 for one edge -> all outputs 0, state IDLE, no err_pulse; without CNT_CHK_STAT_EN, err_cnt reads 0 throughout REQ-031.

Source files
------------

// File: rtl/cnt_chk_if.sv
// Count-checker bus: monitored count stream in, lock/error status out.
interface cnt_chk_if #(
    parameter int WIDTH = 10
) ();
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_vld;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic [15:0]      err_cnt;
    logic [WIDTH-1:0] exp_cnt;

    modport master (
        output cnt_in, cnt_vld, clr,
        input  locked, err_pulse, err_cnt, exp_cnt
    );

    modport slave (
        input  cnt_in, cnt_vld, clr,
        output locked, err_pulse, err_cnt, exp_cnt
    );
endinterface

// File: rtl/cnt_checker.sv
// Sequence checker for an incrementing count: acquires lock after LOCK_N in-order samples.
// Define CNT_CHK_STAT_EN to build in the saturating error counter and its clr input.
module cnt_checker #(
    parameter int WIDTH  = 10,
    parameter int LOCK_N = 4
) (
    input logic      sclk,
    input logic      rst_n,
    cnt_chk_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d, run_inc;
    logic [WIDTH-1:0] exp_q, exp_d, cnt_nxt;
    logic             locked_q, pulse_q;
    logic             brk, match;

    assign cnt_nxt = bus.cnt_in + WIDTH'(1);
    assign match   = (bus.cnt_in == exp_q);
    assign run_inc = run_q + 4'd1;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        exp_d   = exp_q;
        brk     = 1'b0;
        if (bus.cnt_vld) begin
            // Every valid sample re-seeds the expectation, matched or not.
            exp_d = cnt_nxt;
            case (state_q)
                IDLE: begin
                    run_d   = 4'd1;
                    state_d = (LOCK_RUN <= 4'd1) ? LOCK : ACQ;
                end
                ACQ: begin
                    if (match) begin
                        run_d   = run_inc;
                        state_d = (run_inc >= LOCK_RUN) ? LOCK : ACQ;
                    end else begin
                        run_d = 4'd1;
                    end
                end
                LOCK: begin
                    if (!match) begin
                        brk     = 1'b1;
                        run_d   = 4'd1;
                        state_d = ACQ;
                    end
                end
                default: begin
                    run_d   = 4'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            run_q    <= 4'd0;
            exp_q    <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            exp_q    <= exp_d;
            locked_q <= (state_d == LOCK);
            pulse_q  <= brk;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = pulse_q;
    assign bus.exp_cnt   = exp_q;

`ifdef CNT_CHK_STAT_EN
    logic [15:0] err_cnt_q;

    // clr wins over a same-edge break; the pulse still fires from brk.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            err_cnt_q <= 16'h0000;
        end else if (bus.clr) begin
            err_cnt_q <= 16'h0000;
        end else if (brk && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    // Statistics disabled: err_cnt is constant zero and clr has no effect.
    assign bus.err_cnt = 16'h0000 & {16{bus.clr}};
`endif
endmodule

// File: tb/tb_cnt_checker.sv
// Directed self-checking bench for cnt_checker (WIDTH=10, LOCK_N=4).
module tb_cnt_checker;
`ifdef CNT_CHK_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic sclk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] exp_err;

    cnt_chk_if #(.WIDTH(10)) bus ();

    cnt_checker #(.WIDTH(10), .LOCK_N(4)) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic v, input logic [9:0] val, input logic c, input logic r);
        @(negedge sclk);
        rst_n       = r;
        bus.cnt_vld = v;
        bus.cnt_in  = val;
        bus.clr     = c;
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 10'd55, 1'b1, 1'b0);
        step(1'b1, 10'd56, 1'b0, 1'b0);
        exp_err = 16'h0000;
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", bus.locked); end
        checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %0b want 0", bus.err_pulse); end
        checks++; if (bus.exp_cnt !== 10'd0) begin errors++; $display("FAIL reset_exp: got %0d want 0", bus.exp_cnt); end
        checks++; if (bus.err_cnt !== 16'h0000) begin errors++; $display("FAIL reset_err: got %h want 0000", bus.err_cnt); end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 10'(i), 1'b0, 1'b1);
            checks++; if (bus.exp_cnt !== 10'(i + 1)) begin errors++; $display("FAIL lock_exp[%0d]: got %0d want %0d", i, bus.exp_cnt, i + 1); end
            checks++; if (bus.locked !== (i == 3)) begin errors++; $display("FAIL lock_locked[%0d]: got %0b want %0b", i, bus.locked, i == 3); end
            checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL lock_pulse[%0d]: got %0b want 0", i, bus.err_pulse); end
        end
    endtask

    task automatic test_break();
        for (int v = 4; v < 10; v++) step(1'b1, 10'(v), 1'b0, 1'b1);
        checks++; if (bus.locked !== 1'b1 || bus.exp_cnt !== 10'd10) begin errors++; $display("FAIL break_pre: locked=%0b exp=%0d want 1/10", bus.locked, bus.exp_cnt); end
        step(1'b1, 10'd12, 1'b0, 1'b1);
        exp_err = STAT ? exp_err + 16'd1 : 16'h0000;
        checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL break_pulse: got %0b want 1", bus.err_pulse); end
        checks++; if (bus.err_cnt !== exp_err) begin errors++; $display("FAIL break_errcnt: got %h want %h", bus.err_cnt, exp_err); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL break_locked: got %0b want 0", bus.locked); end
        checks++; if (bus.exp_cnt !== 10'd13) begin errors++; $display("FAIL break_exp: got %0d want 13", bus.exp_cnt); end
        for (int v = 13; v < 16; v++) begin
            step(1'b1, 10'(v), 1'b0, 1'b1);
            checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL relock_pulse[%0d]: got %0b want 0", v, bus.err_pulse); end
            checks++; if (bus.locked !== (v == 15)) begin errors++; $display("FAIL relock_locked[%0d]: got %0b want %0b", v, bus.locked, v == 15); end
            checks++; if (bus.err_cnt !== exp_err) begin errors++; $display("FAIL relock_errcnt[%0d]: got %h want %h", v, bus.err_cnt, exp_err); end
        end
        checks++; if (bus.exp_cnt !== 10'd16) begin errors++; $display("FAIL relock_exp: got %0d want 16", bus.exp_cnt); end
    endtask

    task automatic test_wrap();
        step(1'b0, 10'd0, 1'b0, 1'b0);
        exp_err = 16'h0000;
        for (int v = 1018; v < 1022; v++) step(1'b1, 10'(v), 1'b0, 1'b1);
        checks++; if (bus.locked !== 1'b1 || bus.exp_cnt !== 10'd1022) begin errors++; $display("FAIL wrap_pre: locked=%0b exp=%0d want 1/1022", bus.locked, bus.exp_cnt); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 10'((1022 + i) % 1024), 1'b0, 1'b1);
            checks++; if (bus.err_pulse !== 1'b0 || bus.locked !== 1'b1) begin errors++; $display("FAIL wrap_step[%0d]: pulse=%0b locked=%0b want 0/1", i, bus.err_pulse, bus.locked); end
        end
        checks++; if (bus.exp_cnt !== 10'd2) begin errors++; $display("FAIL wrap_exp: got %0d want 2", bus.exp_cnt); end
    endtask

    task automatic test_vld_gap();
        for (int v = 2; v < 6; v++) step(1'b1, 10'(v), 1'b0, 1'b1);
        checks++; if (bus.exp_cnt !== 10'd6) begin errors++; $display("FAIL gap_first: got %0d want 6", bus.exp_cnt); end
        step(1'b0, 10'd99, 1'b0, 1'b1);
        checks++; if (bus.exp_cnt !== 10'd6 || bus.locked !== 1'b1 || bus.err_pulse !== 1'b0) begin errors++; $display("FAIL gap_hold1: exp=%0d locked=%0b pulse=%0b want 6/1/0", bus.exp_cnt, bus.locked, bus.err_pulse); end
        step(1'b0, 10'd77, 1'b0, 1'b1);
        checks++; if (bus.exp_cnt !== 10'd6 || bus.locked !== 1'b1 || bus.err_pulse !== 1'b0) begin errors++; $display("FAIL gap_hold2: exp=%0d locked=%0b pulse=%0b want 6/1/0", bus.exp_cnt, bus.locked, bus.err_pulse); end
        step(1'b1, 10'd6, 1'b0, 1'b1);
        checks++; if (bus.exp_cnt !== 10'd7 || bus.locked !== 1'b1 || bus.err_pulse !== 1'b0) begin errors++; $display("FAIL gap_last: exp=%0d locked=%0b pulse=%0b want 7/1/0", bus.exp_cnt, bus.locked, bus.err_pulse); end
    endtask

    task automatic test_saturate();
`ifdef CNT_CHK_STAT_EN
        @(negedge sclk);
        bus.cnt_vld = 1'b0;
        force dut.err_cnt_q = 16'hFFFE;
        @(posedge sclk);
        #1;
        release dut.err_cnt_q;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 10'(100 * (k + 1)), 1'b0, 1'b1);
            checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse[%0d]: got %0b want 1", k, bus.err_pulse); end
            checks++; if (bus.err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_errcnt[%0d]: got %h want FFFF", k, bus.err_cnt); end
            for (int j = 1; j < 4; j++) step(1'b1, 10'(100 * (k + 1) + j), 1'b0, 1'b1);
            checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL sat_relock[%0d]: got %0b want 1", k, bus.locked); end
        end
        step(1'b1, 10'd300, 1'b1, 1'b1);
        checks++; if (bus.err_cnt !== 16'h0000 || bus.err_pulse !== 1'b1) begin errors++; $display("FAIL sat_clr_break: err=%h pulse=%0b want 0000/1", bus.err_cnt, bus.err_pulse); end
`endif
    endtask

    task automatic test_clr();
        step(1'b0, 10'd0, 1'b0, 1'b0);
        exp_err = 16'h0000;
        for (int v = 20; v < 24; v++) step(1'b1, 10'(v), 1'b0, 1'b1);
        step(1'b1, 10'd30, 1'b0, 1'b1);
        exp_err = STAT ? 16'd1 : 16'd0;
        checks++; if (bus.err_cnt !== exp_err) begin errors++; $display("FAIL clr_pre: got %h want %h", bus.err_cnt, exp_err); end
        step(1'b0, 10'd0, 1'b1, 1'b1);
        checks++; if (bus.err_cnt !== 16'h0000) begin errors++; $display("FAIL clr_only: got %h want 0000", bus.err_cnt); end
        checks++; if (bus.exp_cnt !== 10'd31 || bus.locked !== 1'b0) begin errors++; $display("FAIL clr_state: exp=%0d locked=%0b want 31/0", bus.exp_cnt, bus.locked); end
        for (int v = 31; v < 34; v++) step(1'b1, 10'(v), 1'b0, 1'b1);
        checks++; if (bus.locked !== 1'b1 || bus.exp_cnt !== 10'd34) begin errors++; $display("FAIL clr_relock: locked=%0b exp=%0d want 1/34", bus.locked, bus.exp_cnt); end
        step(1'b1, 10'd40, 1'b1, 1'b1);
        checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL clr_break_pulse: got %0b want 1", bus.err_pulse); end
        checks++; if (bus.err_cnt !== 16'h0000) begin errors++; $display("FAIL clr_break_err: got %h want 0000", bus.err_cnt); end
        checks++; if (bus.exp_cnt !== 10'd41 || bus.locked !== 1'b0) begin errors++; $display("FAIL clr_break_state: exp=%0d locked=%0b want 41/0", bus.exp_cnt, bus.locked); end
    endtask

    task automatic test_reset_in_lock();
        step(1'b0, 10'd0, 1'b0, 1'b0);
        for (int v = 60; v < 64; v++) step(1'b1, 10'(v), 1'b0, 1'b1);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL ril_pre: got %0b want 1", bus.locked); end
        step(1'b1, 10'd99, 1'b0, 1'b0);
        checks++; if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0) begin errors++; $display("FAIL ril_status: locked=%0b pulse=%0b want 0/0", bus.locked, bus.err_pulse); end
        checks++; if (bus.exp_cnt !== 10'd0 || bus.err_cnt !== 16'h0000) begin errors++; $display("FAIL ril_regs: exp=%0d err=%h want 0/0000", bus.exp_cnt, bus.err_cnt); end
        step(1'b1, 10'd50, 1'b0, 1'b1);
        checks++; if (bus.exp_cnt !== 10'd51 || bus.locked !== 1'b0 || bus.err_pulse !== 1'b0) begin errors++; $display("FAIL ril_first: exp=%0d locked=%0b pulse=%0b want 51/0/0", bus.exp_cnt, bus.locked, bus.err_pulse); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_err     = 16'h0000;
        rst_n       = 1'b0;
        bus.cnt_vld = 1'b0;
        bus.cnt_in  = 10'd0;
        bus.clr     = 1'b0;
        test_reset();
        test_lock();
        test_break();
        test_wrap();
        test_vld_gap();
        test_saturate();
        test_clr();
        test_reset_in_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
